// File: rtl/signmag_decoder.sv
// Bit-serial two's-complement to sign-magnitude converter.
// One operand bit is processed per clock, LSB first.
module signmag_decoder #(
    parameter int WIDTH = 8
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    start,
    input  logic signed [WIDTH-1:0] a_in,
    output logic                    busy,
    output logic                    done,
    output logic                    sign,
    output logic        [WIDTH-1:0] mag
);

    localparam int CNT_W = $clog2(WIDTH);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_SHIFT = 2'd1;
    localparam logic [1:0] S_DONE  = 2'd2;

    logic [1:0]       state;
    logic [WIDTH-1:0] shreg;
    logic [WIDTH-1:0] result;
    logic [CNT_W-1:0] cnt;
    logic             pend_sign;
    logic             seen_one;

    logic             accept;
    logic             obit;
    logic             last_bit;
    logic [WIDTH-1:0] result_next;

    // Serial negation: copy bits up to and including the first 1, then invert.
    function automatic logic serial_bit(input logic b, input logic neg, input logic seen);
        return (neg && seen) ? ~b : b;
    endfunction

    assign accept      = start && ((state == S_IDLE) || (state == S_DONE));
    assign obit        = serial_bit(shreg[0], pend_sign, seen_one);
    assign last_bit    = (cnt == CNT_W'(WIDTH - 1));
    assign result_next = {obit, result[WIDTH-1:1]};

    assign busy = (state == S_SHIFT);
    assign done = (state == S_DONE);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= S_IDLE;
            shreg     <= '0;
            result    <= '0;
            cnt       <= '0;
            pend_sign <= 1'b0;
            seen_one  <= 1'b0;
            sign      <= 1'b0;
            mag       <= '0;
        end else begin
            case (state)
                S_IDLE, S_DONE: begin
                    if (accept) begin
                        state     <= S_SHIFT;
                        shreg     <= a_in;
                        pend_sign <= a_in[WIDTH-1];
                        cnt       <= '0;
                        seen_one  <= 1'b0;
                    end else begin
                        state     <= S_IDLE;
                    end
                end
                S_SHIFT: begin
                    shreg  <= shreg >> 1;
                    result <= result_next;
                    cnt    <= cnt + CNT_W'(1);
                    if (pend_sign && shreg[0])
                        seen_one <= 1'b1;
                    // Outputs change only on the edge that completes the last bit.
                    if (last_bit) begin
                        state <= S_DONE;
                        sign  <= pend_sign;
                        mag   <= result_next;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_signmag_decoder.sv
// Self-checking bench for signmag_decoder (WIDTH = 8): directed table,
// multi-cycle corner sequences, exhaustive sweep and back-to-back random runs.
module tb_signmag_decoder;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         start = 1'b1;
    logic [W-1:0] a_in = '0;
    logic         busy, done, sign;
    logic [W-1:0] mag;

    int tests = 0;
    int fails = 0;

    logic         exp_sign = 1'b0;
    logic [W-1:0] exp_mag  = '0;

    typedef struct {
        logic [W-1:0] a;
        logic         s;
        logic [W-1:0] m;
    } vec_t;

    vec_t vecs[9];

    signmag_decoder #(.WIDTH(W)) dut (
        .clk   (clk),
        .reset (rst),
        .start (start),
        .a_in  (a_in),
        .busy  (busy),
        .done  (done),
        .sign  (sign),
        .mag   (mag)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog timeout tests=%0d", tests);
        $fatal(1, "watchdog");
    end

    // Reference: value as a signed integer, magnitude by plain absolute value.
    function automatic logic [W-1:0] ref_mag(input logic [W-1:0] a);
        int v;
        v = a[W-1] ? int'(a) - (1 << W) : int'(a);
        if (v < 0) v = -v;
        return v[W-1:0];
    endfunction

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s got=%0h exp=%0h at %0t", nm, got, exp, $time);
        end
    endtask

    // Called at a negedge: presents the operand, waits for the accepting edge.
    task automatic start_at(input logic [W-1:0] a);
        start = 1'b1;
        a_in  = a;
        @(posedge clk);
        #1;
        start = 1'b0;
        a_in  = W'($urandom);
    endtask

    task automatic busy_chk(input int n, input string nm);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            chk({nm, " busy"}, busy, 1);
            chk({nm, " done"}, done, 0);
            chk({nm, " hold"}, {sign, mag}, {exp_sign, exp_mag});
            if (!start) a_in = W'($urandom);
        end
    endtask

    task automatic done_chk(input logic s, input logic [W-1:0] m, input string nm);
        @(negedge clk);
        chk({nm, " done"}, done, 1);
        chk({nm, " busy@done"}, busy, 0);
        chk({nm, " result"}, {sign, mag}, {s, m});
        exp_sign = s;
        exp_mag  = m;
    endtask

    task automatic run_conv(input logic [W-1:0] a, input logic s, input logic [W-1:0] m,
                            input string nm);
        start_at(a);
        busy_chk(8, nm);
        done_chk(s, m, nm);
        @(negedge clk);
        chk({nm, " done end"}, {busy, done}, 2'b00);
    endtask

    initial begin
        vecs[0] = '{8'h05, 1'b0, 8'h05};
        vecs[1] = '{8'hFB, 1'b1, 8'h05};
        vecs[2] = '{8'hFF, 1'b1, 8'h01};
        vecs[3] = '{8'h80, 1'b1, 8'h80};
        vecs[4] = '{8'h00, 1'b0, 8'h00};
        vecs[5] = '{8'h7F, 1'b0, 8'h7F};
        vecs[6] = '{8'h81, 1'b1, 8'h7F};
        vecs[7] = '{8'hC0, 1'b1, 8'h40};
        vecs[8] = '{8'h01, 1'b0, 8'h01};

        // Reset held with start high: everything stays zero.
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("reset busy/done", {busy, done}, 2'b00);
            chk("reset sign/mag", {sign, mag}, 9'h000);
        end
        rst   = 1'b0;
        start = 1'b0;
        @(negedge clk);
        chk("post-reset idle", {busy, done, sign, mag}, 11'h000);

        for (int i = 0; i < 9; i++)
            run_conv(vecs[i].a, vecs[i].s, vecs[i].m, $sformatf("vec%0d", i));

        // Start during SHIFT is ignored; start in DONE chains the next conversion.
        @(negedge clk);
        start_at(8'h7F);
        busy_chk(3, "busy-start a");
        start_at(8'h81);
        busy_chk(5, "busy-start b");
        done_chk(1'b0, 8'h7F, "busy-start");
        start_at(8'h81);
        busy_chk(8, "done-start");
        done_chk(1'b1, 8'h7F, "done-start");
        @(negedge clk);
        chk("done-start end", {busy, done}, 2'b00);

        // Asynchronous reset between edges N+4 and N+5.
        start_at(8'hC0);
        busy_chk(4, "midreset");
        #2;
        rst = 1'b1;
        #1;
        chk("midreset immediate", {busy, done, sign, mag}, 11'h000);
        exp_sign = 1'b0;
        exp_mag  = '0;
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("midreset no done", {busy, done, sign, mag}, 11'h000);
        end
        run_conv(8'hC0, 1'b1, 8'h40, "after-reset");

        // Exhaustive sweep against the arithmetic reference.
        for (int a = 0; a < 256; a++)
            run_conv(W'(a), a[7], ref_mag(W'(a)), $sformatf("exh%0h", a));

        // Start held high: one conversion every 9 cycles, random operands.
        start = 1'b1;
        a_in  = W'($urandom);
        for (int k = 0; k < 20; k++) begin
            logic [W-1:0] v;
            v = a_in;
            @(posedge clk);
            #1;
            a_in = W'($urandom);
            for (int i = 0; i < 8; i++) begin
                @(negedge clk);
                chk("b2b busy", {busy, done}, 2'b10);
                chk("b2b hold", {sign, mag}, {exp_sign, exp_mag});
                a_in = W'($urandom);
            end
            done_chk(v[7], ref_mag(v), "b2b");
            a_in = W'($urandom);
        end
        start = 1'b0;
        @(negedge clk);
        chk("b2b end", {busy, done}, 2'b00);
        chk("b2b final hold", {sign, mag}, {exp_sign, exp_mag});

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
